// File: rtl/pwm_compare_dt_16bits_pkg.sv
// Shared types and widths for the PWM compare / dead-time leg.
// Build option: PWM_DEADTIME_EN selects the dead-time FSM; undefined gives direct complementary outputs.
package pwm_compare_dt_16bits_pkg;

  localparam int PWMCOUNT_WIDTH = 16;
  localparam int DEADTIME_WIDTH = 10;

  typedef enum logic [2:0] {
    OFF   = 3'd0,
    L_ON  = 3'd1,
    DT_LH = 3'd2,
    H_ON  = 3'd3,
    DT_HL = 3'd4
  } dt_state_e;

  function automatic logic ref_level(input logic below, input logic pol);
    return below ^ pol;
  endfunction

endpackage

// File: rtl/pwm_compare_dt_16bits_deadtime_gen.sv
// Gate-pair generator: turns the registered reference into pwm_h/pwm_l.
// Build option: PWM_DEADTIME_EN inserts a both-low gap of deadtime_sh cycles on every side change.
module pwm_compare_dt_16bits_deadtime_gen
  import pwm_compare_dt_16bits_pkg::*;
`ifdef PWM_DEADTIME_EN
#(
  parameter int DT_WIDTH = DEADTIME_WIDTH
)
`endif
(
  input  logic                clk,
  input  logic                reset,
  input  logic                pwm_ref,
  input  logic                pwm_onoff,
`ifdef PWM_DEADTIME_EN
  input  logic [DT_WIDTH-1:0] deadtime_sh,
`endif
  output logic                pwm_h,
  output logic                pwm_l
);

  logic pwm_h_q, pwm_h_d;
  logic pwm_l_q, pwm_l_d;

`ifdef PWM_DEADTIME_EN
  dt_state_e           state_q, state_d;
  logic [DT_WIDTH-1:0] cnt_q, cnt_d;

  // Next state: a gap is abandoned if the reference reverts before it expires.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (!pwm_onoff) begin
      state_d = OFF;
      cnt_d   = '0;
    end else begin
      case (state_q)
        OFF: begin
          state_d = pwm_ref ? H_ON : L_ON;
          cnt_d   = '0;
        end
        L_ON: begin
          if (!pwm_ref) begin
            state_d = L_ON;
          end else if (deadtime_sh == '0) begin
            state_d = H_ON;
          end else begin
            state_d = DT_LH;
            cnt_d   = deadtime_sh - DT_WIDTH'(1);
          end
        end
        DT_LH: begin
          if (!pwm_ref) begin
            state_d = L_ON;
            cnt_d   = '0;
          end else if (cnt_q == '0) begin
            state_d = H_ON;
          end else begin
            cnt_d = cnt_q - DT_WIDTH'(1);
          end
        end
        H_ON: begin
          if (pwm_ref) begin
            state_d = H_ON;
          end else if (deadtime_sh == '0) begin
            state_d = L_ON;
          end else begin
            state_d = DT_HL;
            cnt_d   = deadtime_sh - DT_WIDTH'(1);
          end
        end
        DT_HL: begin
          if (pwm_ref) begin
            state_d = H_ON;
            cnt_d   = '0;
          end else if (cnt_q == '0) begin
            state_d = L_ON;
          end else begin
            cnt_d = cnt_q - DT_WIDTH'(1);
          end
        end
        default: begin
          state_d = OFF;
          cnt_d   = '0;
        end
      endcase
    end
    pwm_h_d = (state_d == H_ON);
    pwm_l_d = (state_d == L_ON);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= OFF;
      cnt_q   <= '0;
      pwm_h_q <= 1'b0;
      pwm_l_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pwm_h_q <= pwm_h_d;
      pwm_l_q <= pwm_l_d;
    end
  end
`else
  always_comb begin
    pwm_h_d = pwm_onoff & pwm_ref;
    pwm_l_d = pwm_onoff & ~pwm_ref;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pwm_h_q <= 1'b0;
      pwm_l_q <= 1'b0;
    end else begin
      pwm_h_q <= pwm_h_d;
      pwm_l_q <= pwm_l_d;
    end
  end
`endif

  assign pwm_h = pwm_h_q;
  assign pwm_l = pwm_l_q;

endmodule

// File: rtl/pwm_compare_dt_16bits.sv
// PWM leg: shadowed compare against the carrier, registered reference, and gate-pair generation.
// Build option: PWM_DEADTIME_EN enables dead-time insertion and the deadtime shadow register.
module pwm_compare_dt_16bits
  import pwm_compare_dt_16bits_pkg::*;
#(
  parameter int CMP_WIDTH = PWMCOUNT_WIDTH,
  parameter int DT_WIDTH  = DEADTIME_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [CMP_WIDTH-1:0] carrier,
  input  logic                 maskevent,
  input  logic                 pwm_onoff,
  input  logic [CMP_WIDTH-1:0] compare,
  input  logic [DT_WIDTH-1:0]  deadtime,
  input  logic                 out_pol,
  output logic                 pwm_h,
  output logic                 pwm_l,
  output logic                 cmp_match
);

  logic [CMP_WIDTH-1:0] compare_sh_q, compare_sh_d;
  logic                 out_pol_sh_q, out_pol_sh_d;
  logic                 ref_q, ref_d;
  logic                 cmp_match_q, cmp_match_d;
  logic                 shadow_load_s;

  // Shadows are transparent while stopped so a restart begins with current settings.
  always_comb begin
    shadow_load_s = maskevent | ~pwm_onoff;
    if (shadow_load_s) begin
      compare_sh_d = compare;
      out_pol_sh_d = out_pol;
    end else begin
      compare_sh_d = compare_sh_q;
      out_pol_sh_d = out_pol_sh_q;
    end
    ref_d       = ref_level(carrier < compare_sh_q, out_pol_sh_q);
    cmp_match_d = pwm_onoff & (carrier == compare_sh_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      compare_sh_q <= '0;
      out_pol_sh_q <= 1'b0;
      ref_q        <= 1'b0;
      cmp_match_q  <= 1'b0;
    end else begin
      compare_sh_q <= compare_sh_d;
      out_pol_sh_q <= out_pol_sh_d;
      ref_q        <= ref_d;
      cmp_match_q  <= cmp_match_d;
    end
  end

`ifdef PWM_DEADTIME_EN
  logic [DT_WIDTH-1:0] deadtime_sh_q, deadtime_sh_d;

  always_comb begin
    if (shadow_load_s) begin
      deadtime_sh_d = deadtime;
    end else begin
      deadtime_sh_d = deadtime_sh_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      deadtime_sh_q <= '0;
    end else begin
      deadtime_sh_q <= deadtime_sh_d;
    end
  end

  pwm_compare_dt_16bits_deadtime_gen #(
    .DT_WIDTH (DT_WIDTH)
  ) u_deadtime_gen (
    .clk         (clk),
    .reset       (reset),
    .pwm_ref     (ref_q),
    .pwm_onoff   (pwm_onoff),
    .deadtime_sh (deadtime_sh_q),
    .pwm_h       (pwm_h),
    .pwm_l       (pwm_l)
  );
`else
  // The deadtime port is kept for pin compatibility but has no function here.
  logic unused_deadtime_s;
  assign unused_deadtime_s = ^deadtime;

  pwm_compare_dt_16bits_deadtime_gen u_deadtime_gen (
    .clk       (clk),
    .reset     (reset),
    .pwm_ref   (ref_q),
    .pwm_onoff (pwm_onoff),
    .pwm_h     (pwm_h),
    .pwm_l     (pwm_l)
  );
`endif

  assign cmp_match = cmp_match_q;

endmodule

// File: tb/tb_pwm_compare_dt_16bits.sv
// Randomized, model-checked bench for pwm_compare_dt_16bits (either PWM_DEADTIME_EN build).
module tb_pwm_compare_dt_16bits;

`ifdef PWM_DEADTIME_EN
  localparam bit DT_EN = 1'b1;
`else
  localparam bit DT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] carrier;
  logic        maskevent;
  logic        pwm_onoff;
  logic [15:0] compare;
  logic [9:0]  deadtime;
  logic        out_pol;
  logic        pwm_h, pwm_l, cmp_match;

  int tests = 0;
  int fails = 0;

  // reference model: shadow values, registered reference, lit side and remaining gap
  logic [15:0] m_cmp_sh;
  logic [9:0]  m_dt_sh;
  logic        m_pol_sh, m_ref, m_h, m_l, m_match;
  int          m_side;   // 0 none, 1 low side, 2 high side
  int          m_gap;    // both-low cycles still to go before switching to m_target
  int          m_target;

  int cnt_h, cnt_l, cnt_match, cnt_both_low;

  pwm_compare_dt_16bits dut (
    .clk       (clk),
    .reset     (reset),
    .carrier   (carrier),
    .maskevent (maskevent),
    .pwm_onoff (pwm_onoff),
    .compare   (compare),
    .deadtime  (deadtime),
    .out_pol   (out_pol),
    .pwm_h     (pwm_h),
    .pwm_l     (pwm_l),
    .cmp_match (cmp_match)
  );

  always #5 clk = ~clk;

  task automatic clear_counts();
    cnt_h = 0; cnt_l = 0; cnt_match = 0; cnt_both_low = 0;
  endtask

  // Advance model and DUT by one clock, then compare all outputs.
  task automatic tick();
    logic n_ref, n_match, n_h, n_l;
    int desired;
    n_match = pwm_onoff && (carrier == m_cmp_sh);
    n_ref   = (carrier < m_cmp_sh) ^ m_pol_sh;
    if (DT_EN) begin
      desired = m_ref ? 2 : 1;
      if (!pwm_onoff) begin
        m_side = 0; m_gap = 0;
      end else if (m_side == 0) begin
        m_side = desired;
      end else if (m_gap > 0) begin
        if (desired != m_target) m_gap = 0;
        else if (m_gap == 1) begin m_side = m_target; m_gap = 0; end
        else m_gap = m_gap - 1;
      end else if (desired != m_side) begin
        if (m_dt_sh == 10'd0) m_side = desired;
        else begin m_gap = int'(m_dt_sh); m_target = desired; end
      end
      n_h = (m_gap == 0) && (m_side == 2);
      n_l = (m_gap == 0) && (m_side == 1);
    end else begin
      n_h = pwm_onoff & m_ref;
      n_l = pwm_onoff & ~m_ref;
    end
    if (!pwm_onoff || maskevent) begin
      m_cmp_sh = compare; m_pol_sh = out_pol; m_dt_sh = deadtime;
    end
    m_ref = n_ref; m_match = n_match; m_h = n_h; m_l = n_l;
    if (reset) begin
      m_cmp_sh = 16'd0; m_pol_sh = 1'b0; m_dt_sh = 10'd0;
      m_ref = 1'b0; m_match = 1'b0; m_h = 1'b0; m_l = 1'b0;
      m_side = 0; m_gap = 0;
    end
    @(posedge clk);
    #1;
    tests++;
    if (pwm_h !== m_h) begin
      fails++;
      $display("FAIL pwm_h @%0t: got %b expected %b", $time, pwm_h, m_h);
    end
    tests++;
    if (pwm_l !== m_l) begin
      fails++;
      $display("FAIL pwm_l @%0t: got %b expected %b", $time, pwm_l, m_l);
    end
    tests++;
    if (cmp_match !== m_match) begin
      fails++;
      $display("FAIL cmp_match @%0t: got %b expected %b", $time, cmp_match, m_match);
    end
    tests++;
    if ((pwm_h & pwm_l) !== 1'b0) begin
      fails++;
      $display("FAIL overlap @%0t: pwm_h=%b pwm_l=%b", $time, pwm_h, pwm_l);
    end
    if (pwm_h === 1'b1) cnt_h++;
    if (pwm_l === 1'b1) cnt_l++;
    if (cmp_match === 1'b1) cnt_match++;
    if (pwm_onoff && pwm_h === 1'b0 && pwm_l === 1'b0) cnt_both_low++;
  endtask

  task automatic hold(input logic [15:0] c, input int n);
    for (int i = 0; i < n; i++) begin
      carrier = c;
      tick();
      maskevent = 1'b0;
    end
  endtask

  // One 0..99 up-count period; maskevent on carrier=0; optional compare rewrite at carrier=60.
  task automatic ramp_period(input logic [15:0] new_cmp, input bit rewrite);
    for (int c = 0; c < 100; c++) begin
      carrier   = 16'(c);
      maskevent = (c == 0);
      if (rewrite && c == 60) compare = new_cmp;
      tick();
    end
    maskevent = 1'b0;
  endtask

  task automatic check_count(input string name, input int got, input int exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; pwm_onoff = 1'b1; compare = 16'd50; deadtime = 10'd5;
    out_pol = 1'b0; maskevent = 1'b1; carrier = 16'd0;
    for (int i = 0; i < 3; i++) begin
      tick();
      tests++;
      if ({pwm_h, pwm_l, cmp_match} !== 3'b000) begin
        fails++;
        $display("FAIL reset_outputs: got %b expected 000", {pwm_h, pwm_l, cmp_match});
      end
    end
    reset = 1'b0; maskevent = 1'b0;
  endtask

  task automatic test_carrier_period();
    compare = 16'd50; deadtime = 10'd5; out_pol = 1'b0;
    ramp_period(16'd0, 1'b0);
    ramp_period(16'd0, 1'b0);
    clear_counts();
    ramp_period(16'd0, 1'b0);
    check_count("period_h_cycles", cnt_h, DT_EN ? 45 : 50);
    check_count("period_l_cycles", cnt_l, DT_EN ? 45 : 50);
    check_count("period_gap_cycles", cnt_both_low, DT_EN ? 10 : 0);
    check_count("period_match_pulses", cnt_match, 1);
  endtask

  task automatic test_duty_update();
    clear_counts();
    ramp_period(16'd20, 1'b1);
    check_count("duty_before_event", cnt_h, DT_EN ? 45 : 50);
    ramp_period(16'd0, 1'b0);
    clear_counts();
    ramp_period(16'd0, 1'b0);
    check_count("duty_after_event", cnt_h, DT_EN ? 15 : 20);
    check_count("match_after_event", cnt_match, 1);
  endtask

  task automatic test_deadtime();
    compare = 16'd50; deadtime = 10'd0; maskevent = 1'b1;
    hold(16'd100, 12);
    clear_counts();
    hold(16'd10, 8);
    hold(16'd100, 8);
    check_count("dt0_gap_cycles", cnt_both_low, 0);
    check_count("dt0_h_cycles", cnt_h, 8);
    deadtime = 10'd10; maskevent = 1'b1;
    hold(16'd100, 15);
    clear_counts();
    hold(16'd10, 4);
    hold(16'd100, 15);
    check_count("short_pulse_h_cycles", cnt_h, DT_EN ? 0 : 4);
    check_count("short_pulse_l_cycles", cnt_l, DT_EN ? 15 : 15);
  endtask

  task automatic test_extremes();
    logic [15:0] cmps [3] = '{16'd0, 16'hFFFF, 16'd0};
    logic        pols [3] = '{1'b0, 1'b0, 1'b1};
    int          exph [3] = '{0, 40, 40};
    deadtime = 10'd3;
    for (int k = 0; k < 3; k++) begin
      compare = cmps[k]; out_pol = pols[k]; maskevent = 1'b1;
      hold(16'($urandom_range(0, 16'hFFFE)), 1);
      for (int i = 0; i < 6; i++) hold(16'($urandom_range(0, 16'hFFFE)), 1);
      clear_counts();
      for (int i = 0; i < 40; i++) hold(16'($urandom_range(0, 16'hFFFE)), 1);
      check_count("extreme_h_cycles", cnt_h, exph[k]);
      check_count("extreme_l_cycles", cnt_l, 40 - exph[k]);
    end
    out_pol = 1'b0;
  endtask

  task automatic test_onoff();
    compare = 16'd50; deadtime = 10'd8; maskevent = 1'b1;
    hold(16'd100, 15);
    hold(16'd10, 3);
    pwm_onoff = 1'b0;
    hold(16'd10, 1);
    tests++;
    if ({pwm_h, pwm_l} !== 2'b00) begin
      fails++;
      $display("FAIL onoff_drop: got %b expected 00", {pwm_h, pwm_l});
    end
    hold(16'd10, 2);
    pwm_onoff = 1'b1;
    hold(16'd10, 1);
    tests++;
    if ({pwm_h, pwm_l} !== 2'b10) begin
      fails++;
      $display("FAIL onoff_restart: got %b expected 10", {pwm_h, pwm_l});
    end
    hold(16'd10, 4);
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      carrier   = 16'($urandom_range(0, 199));
      maskevent = ($urandom_range(0, 7) == 0);
      pwm_onoff = ($urandom_range(0, 39) != 0);
      reset     = ($urandom_range(0, 499) == 0);
      if ($urandom_range(0, 15) == 0) compare = 16'($urandom_range(0, 200));
      if ($urandom_range(0, 15) == 0) deadtime = 10'($urandom_range(0, 12));
      if ($urandom_range(0, 63) == 0) out_pol = ~out_pol;
      tick();
    end
    reset = 1'b0; pwm_onoff = 1'b1; maskevent = 1'b0;
  endtask

  initial begin
    m_cmp_sh = 16'd0; m_dt_sh = 10'd0; m_pol_sh = 1'b0; m_ref = 1'b0;
    m_h = 1'b0; m_l = 1'b0; m_match = 1'b0; m_side = 0; m_gap = 0; m_target = 0;
    clear_counts();
    test_reset();
    test_carrier_period();
    test_duty_update();
    test_deadtime();
    test_extremes();
    test_onoff();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
